// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing stage: PC, IR and flag register plus the FETCH/EXEC state machine.
// Optional single-step mode is compiled in with FETCH_SEQ_STEP_EN (adds the step input and STEP_WAIT).
module fetch_sequencer #(
  parameter int PC_W    = 3,
  parameter int INSTR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
`ifdef FETCH_SEQ_STEP_EN
  input  logic               step,
`endif
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_ready,
  input  logic               jmp_sel,
  input  logic               flag_we,
  input  logic               alu_zf,
  input  logic               alu_sf,
  input  logic               alu_cf,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd,
  output logic [PC_W-1:0]    pc,
  output logic [3:0]         opcode,
  output logic [2:0]         field_a,
  output logic [2:0]         field_b,
  output logic               zf,
  output logic               sf,
  output logic               cf,
  output logic               exec_valid,
  output logic               halted
);

  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
`ifdef FETCH_SEQ_STEP_EN
    S_STEP_WAIT,
`endif
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [2:0]         flags_q, flags_d;
  logic [PC_W-1:0]    jmp_tgt;

  // Jump target is the low IR field, zero-extended for wide PCs and truncated for narrow ones.
  always_comb begin
    jmp_tgt = '0;
    for (int i = 0; i < PC_W; i++) begin
      if (i < 3) jmp_tgt[i] = ir_q[i];
    end
  end

`ifdef FETCH_SEQ_STEP_EN
  // A held step advances once; it must drop low before it can release STEP_WAIT again.
  logic step_armed_q, step_armed_d;

  always_comb begin
    step_armed_d = step_armed_q;
    if (!step) step_armed_d = 1'b1;
    else if (state_q == S_STEP_WAIT && step_armed_q) step_armed_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_armed_q <= 1'b1;
    else        step_armed_q <= step_armed_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        pc_d = jmp_sel ? jmp_tgt : pc_q + PC_W'(1);
        if (flag_we) flags_d = {alu_zf, alu_sf, alu_cf};
        if (ir_q[9:6] == OP_HALT) state_d = S_HALT;
`ifdef FETCH_SEQ_STEP_EN
        else                      state_d = S_STEP_WAIT;
`else
        else if (run)             state_d = S_FETCH;
        else                      state_d = S_IDLE;
`endif
      end
`ifdef FETCH_SEQ_STEP_EN
      S_STEP_WAIT: begin
        if (step && step_armed_q) state_d = S_FETCH;
        else if (!run)            state_d = S_IDLE;
      end
`endif
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  assign imem_addr  = pc_q;
  assign imem_rd    = (state_q == S_FETCH);
  assign pc         = pc_q;
  assign opcode     = ir_q[9:6];
  assign field_a    = ir_q[5:3];
  assign field_b    = ir_q[2:0];
  assign zf         = flags_q[2];
  assign sf         = flags_q[1];
  assign cf         = flags_q[0];
  assign exec_valid = (state_q == S_EXEC);
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: instruction-level model plus directed programs with literal expectations.
module tb_fetch_sequencer;
  localparam int PC_W    = 3;
  localparam int INSTR_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
`ifdef FETCH_SEQ_STEP_EN
  logic step = 1'b0;
`endif
  logic [INSTR_W-1:0] imem_data;
  logic imem_ready, jmp_sel, flag_we, alu_zf, alu_sf, alu_cf;
  logic [PC_W-1:0] imem_addr, pc;
  logic imem_rd, zf, sf, cf, exec_valid, halted;
  logic [3:0] opcode;
  logic [2:0] field_a, field_b;

  fetch_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef FETCH_SEQ_STEP_EN
    .step(step),
`endif
    .imem_data(imem_data), .imem_ready(imem_ready), .jmp_sel(jmp_sel), .flag_we(flag_we),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_cf(alu_cf),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .pc(pc), .opcode(opcode),
    .field_a(field_a), .field_b(field_b), .zf(zf), .sf(sf), .cf(cf),
    .exec_valid(exec_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  // Instruction memory with a programmable number of wait cycles per fetch.
  logic [INSTR_W-1:0] mem [8];
  int waits = 0;
  int rd_cnt;
  assign imem_data  = mem[imem_addr];
  assign imem_ready = (rd_cnt == waits);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     rd_cnt <= 0;
    else if (imem_rd && !imem_ready) rd_cnt <= rd_cnt + 1;
    else                            rd_cnt <= 0;
  end

  // Per-instruction control-unit decisions; noise is driven outside EXEC.
  logic       jmp_tab [16];
  logic       we_tab  [16];
  logic [2:0] alu_tab [16];
  logic [3:0] m_idx;
  logic [2:0] cyc = 3'd0;
  always @(posedge clk) cyc <= cyc + 3'd1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          m_idx <= 4'd0;
    else if (exec_valid) m_idx <= m_idx + 4'd1;
  end
  assign jmp_sel = exec_valid ? jmp_tab[m_idx] : cyc[0];
  assign flag_we = exec_valid ? we_tab[m_idx]  : cyc[1];
  assign {alu_zf, alu_sf, alu_cf} = exec_valid ? alu_tab[m_idx] : ~alu_tab[m_idx];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Instruction-level model: expected PC, flags and halt status, updated once per executed instruction.
  logic [PC_W-1:0]    m_pc;
  logic [2:0]         m_flags;
  logic               m_halt;
  int                 flen;
  logic [INSTR_W-1:0] m_ir;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc = '0; m_flags = '0; m_halt = 1'b0; flen = 0;
      chk("reset_outputs", {imem_rd, exec_valid, halted, pc, imem_addr, opcode, field_a, field_b, zf, sf, cf}, 32'd0);
    end else begin
      chk("pc", pc, m_pc);
      chk("flags", {zf, sf, cf}, m_flags);
      chk("halted", halted, m_halt);
      if (imem_rd) begin
        chk("fetch_addr", imem_addr, m_pc);
        chk("rd_with_exec", exec_valid, 1'b0);
        flen++;
      end
      if (exec_valid) begin
        m_ir = mem[m_pc];
        chk("exec_ir", {opcode, field_a, field_b}, m_ir);
        chk("fetch_len", flen, waits + 1);
        flen = 0;
        if (m_ir[9:6] == 4'b1111) m_halt = 1'b1;
        m_pc = jmp_sel ? m_ir[2:0] : m_pc + 3'd1;
        if (flag_we) m_flags = {alu_zf, alu_sf, alu_cf};
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 8; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) begin
      jmp_tab[i] = 1'b0; we_tab[i] = 1'b0; alu_tab[i] = 3'b000;
    end
  endtask

  task automatic enter_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_exec(input string tag);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exec_valid) break;
    end
    if (!exec_valid) begin
      checks++;
      $display("FAIL %s: exec_valid not seen within 60 cycles, got 0, expected 1", tag);
    end
  endtask

  int n;

  initial begin
    clear_prog();
    // Basic fetch/exec with zero-wait memory, pause and resume.
    enter_reset();
    mem[0] = 10'b0001_001_010;
    mem[1] = 10'b0010_011_100;
    waits = 0;
    chk("rst_pc", pc, 3'd0);
    chk("rst_opcode", opcode, 4'd0);
    rst_n = 1'b1; run = 1'b1;
    @(posedge clk); #1;
    chk("t1_rd_cycle1", imem_rd, 1'b1);
    chk("t1_addr_cycle1", imem_addr, 3'd0);
    @(posedge clk); #1;
    chk("t1_exec_cycle2", exec_valid, 1'b1);
    chk("t1_opcode", opcode, 4'b0001);
    chk("t1_fields", {field_a, field_b}, 6'b001_010);
    run = 1'b0;
    @(posedge clk); #1;
    chk("t1_pc_after", pc, 3'd1);
    repeat (3) begin
      chk("t1_idle_no_rd", imem_rd, 1'b0);
      @(posedge clk); #1;
    end
    run = 1'b1;
    @(posedge clk); #1;
    chk("t1_resume_addr", imem_addr, 3'd1);
    @(posedge clk); #1;
    chk("t1_resume_opcode", opcode, 4'b0010);
    run = 1'b0;
    @(posedge clk); #1;
    chk("t1_pc2", pc, 3'd2);

    // Three memory wait cycles.
    enter_reset();
    clear_prog();
    mem[0] = 10'b0001_001_010;
    waits = 3;
    rst_n = 1'b1; run = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_wait_rd", imem_rd, 1'b1);
      chk("t2_wait_addr", imem_addr, 3'd0);
      chk("t2_no_exec", exec_valid, 1'b0);
      @(posedge clk); #1;
    end
    chk("t2_exec", exec_valid, 1'b1);
    run = 1'b0;
    @(posedge clk); #1;
    chk("t2_single_exec", exec_valid, 1'b0);
    chk("t2_pc", pc, 3'd1);

    // Jumps, wrap-around, flag latching and a halting instruction.
    enter_reset();
    clear_prog();
    waits = 0;
    mem[0] = 10'b0100_000_101;
    mem[5] = 10'b0011_001_001;
    mem[6] = 10'b0101_000_000;
    mem[7] = 10'b0001_111_111;
    mem[1] = 10'b1111_000_000;
    jmp_tab[0] = 1'b1; we_tab[0] = 1'b1; alu_tab[0] = 3'b101;
    alu_tab[1] = 3'b010;
    we_tab[2] = 1'b1; alu_tab[2] = 3'b010;
    alu_tab[3] = 3'b111;
    we_tab[5] = 1'b1; alu_tab[5] = 3'b011;
    rst_n = 1'b1; run = 1'b1;
    wait_exec("t3_exec0");
    chk("t3_op0", opcode, 4'b0100);
    chk("t3_flags_not_yet", {zf, sf, cf}, 3'b000);
    @(posedge clk); #1;
    chk("t3_jump_addr", imem_addr, 3'd5);
    chk("t3_flags_101", {zf, sf, cf}, 3'b101);
    wait_exec("t3_exec1");
    chk("t3_pc5", pc, 3'd5);
    @(posedge clk); #1;
    chk("t3_addr6", imem_addr, 3'd6);
    chk("t3_flags_hold", {zf, sf, cf}, 3'b101);
    wait_exec("t3_exec2");
    @(posedge clk); #1;
    chk("t3_flags_010", {zf, sf, cf}, 3'b010);
    wait_exec("t3_exec3");
    chk("t3_pc7", pc, 3'd7);
    @(posedge clk); #1;
    chk("t3_wrap_addr", imem_addr, 3'd0);
    wait_exec("t3_exec4");
    @(posedge clk); #1;
    chk("t3_nojump_addr", imem_addr, 3'd1);
    wait_exec("t3_exec5");
    chk("t3_halt_op", opcode, 4'b1111);
    @(posedge clk); #1;
    chk("t3_halted", halted, 1'b1);
    chk("t3_halt_pc", pc, 3'd2);
    chk("t3_halt_flags", {zf, sf, cf}, 3'b011);

    // Halt at address 2, then leave only through reset.
    enter_reset();
    clear_prog();
    mem[0] = 10'b0001_001_010;
    mem[1] = 10'b0010_011_100;
    mem[2] = 10'b1111_000_000;
    rst_n = 1'b1; run = 1'b1;
    wait_exec("t4_exec0");
    wait_exec("t4_exec1");
    wait_exec("t4_exec2");
    chk("t4_halt_op", opcode, 4'b1111);
    @(posedge clk); #1;
    chk("t4_halted", halted, 1'b1);
    chk("t4_pc3", pc, 3'd3);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_rd) n++;
    end
    chk("t4_no_rd_20", n, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; run = 1'b0;
    #1;
    chk("t4_rst_pc", pc, 3'd0);
    chk("t4_rst_halted", halted, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t4_idle_after_rst", imem_rd, 1'b0);
    end

    // Asynchronous reset in the middle of a wait-stated fetch.
    enter_reset();
    clear_prog();
    mem[0] = 10'b0001_001_010;
    waits = 3;
    we_tab[0] = 1'b1; alu_tab[0] = 3'b111;
    rst_n = 1'b1; run = 1'b1;
    wait_exec("t5_exec0");
    @(posedge clk); #1;
    chk("t5_pre_pc", pc, 3'd1);
    chk("t5_pre_flags", {zf, sf, cf}, 3'b111);
    chk("t5_pre_rd", imem_rd, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_rd", imem_rd, 1'b0);
    chk("t5_async_pc", {pc, imem_addr}, 6'd0);
    chk("t5_async_ir", {opcode, field_a, field_b}, 10'd0);
    chk("t5_async_flags", {zf, sf, cf}, 3'b000);
    chk("t5_async_ctrl", {exec_valid, halted}, 2'b00);
    @(posedge clk); #1;
    waits = 0;

`ifdef FETCH_SEQ_STEP_EN
    // Single stepping: one instruction per step visit, even with step held high.
    enter_reset();
    clear_prog();
    for (int i = 0; i < 8; i++) mem[i] = 10'b0001_000_000;
    step = 1'b0;
    rst_n = 1'b1; run = 1'b1;
    wait_exec("t6_exec0");
    @(posedge clk); #1;
    repeat (3) begin
      chk("t6_wait_no_rd", imem_rd, 1'b0);
      @(posedge clk); #1;
    end
    for (int p = 0; p < 2; p++) begin
      step = 1'b1;
      n = 0;
      repeat (8) begin
        @(negedge clk);
        if (exec_valid) n++;
      end
      chk("t6_one_exec_per_step", n, 1);
      @(posedge clk); #1;
      step = 1'b0;
      @(posedge clk); #1;
    end
`endif

    enter_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and sequencing stage of the 3-bit CPU, directly upstream of the control unit. Holds the program counter, instruction register and flag register. Runs a FETCH/EXEC state machine against a wait-stated instruction memory. Presents the current opcode and latched ZF/SF/CF to the control unit, and applies its jump decision to the PC.

## Interface
- `PC_W`, 3, program counter width; program space is 2^PC_W words; legal range 2..6.
- `INSTR_W`, 10, instruction width; fields are `{opcode[3:0], field_a[2:0], field_b[2:0]}`.
- `clk` in 1: single clock, all state on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: level; permits leaving IDLE and continuing after EXEC.
- `imem_data` in INSTR_W: instruction word from instruction memory.
- `imem_ready` in 1: memory has valid `imem_data` for `imem_addr` this cycle.
- `jmp_sel` in 1: control-unit jump decision, sampled only in EXEC.
- `flag_we` in 1: latch ALU flags, sampled only in EXEC.
- `alu_zf`, `alu_sf`, `alu_cf` in 1 each: ALU flag results.
- `imem_addr` out PC_W: fetch address, equal to `pc`.
- `imem_rd` out 1: fetch request.
- `pc` out PC_W: program counter.
- `opcode` out 4: `IR[9:6]`, to the control unit.
- `field_a`, `field_b` out 3 each: `IR[5:3]`, `IR[2:0]`.
- `zf`, `sf`, `cf` out 1 each: latched flags, to the control unit.
- `exec_valid` out 1: high for exactly the EXEC cycle; gates all register-file and flag writes downstream.
- `halted` out 1: high in HALT.

## Operation
- States: IDLE, FETCH, EXEC, HALT, plus STEP_WAIT when stepping is compiled in.
- **IDLE**
  - `run`=1 → FETCH.
  - `run`=0 → stay.
- **FETCH**
  - Drives `imem_rd`=1 and `imem_addr`=`pc`.
  - On `imem_ready`=1: IR←`imem_data`, go to EXEC.
  - Otherwise stay, holding address and request stable.
  - `run` is ignored in FETCH.
- **EXEC** (always exactly one cycle, `exec_valid`=1)
  - Control unit decodes `opcode` and the flags combinationally.
  - On the clock edge, `pc` ← `jmp_sel` ? `IR[PC_W-1:0]` (zero-extended when PC_W > 3) : `pc`+1.
  - Increment wraps modulo 2^PC_W; the last address goes to 0.
  - If `flag_we`=1, {zf,sf,cf} ← ALU flags; otherwise flags hold.
  - Flags written in EXEC are visible to the next instruction's EXEC, never the current one.
- **Next state after EXEC**
  - `opcode`=4'b1111 → HALT. The PC update and flag update still occur.
  - Otherwise `run`=1 → FETCH.
  - Otherwise `run`=0 → IDLE (pause). A later `run`=1 resumes at the updated `pc`.
- **HALT**: absorbing. Leaves only via `rst_n`. `halted`=1 and `imem_rd`=0.
- **Reset (any time, including mid-FETCH with `imem_ready` pending)**
  - State=IDLE.
  - `pc`=0, IR=0 (`opcode`=0000, fields 0).
  - zf=sf=cf=0.
  - `imem_rd`=0, `exec_valid`=0, `halted`=0.
  - A pending fetch is dropped.

## Timing
- IDLE→FETCH costs one cycle after `run` is seen high.
- Zero-wait memory (`imem_ready` high in the first FETCH cycle): two cycles per instruction (FETCH, EXEC).
- Each memory wait cycle adds one cycle.
- `imem_ready` outside FETCH is ignored.
- `jmp_sel` and `flag_we` outside EXEC are ignored.
- Outputs `opcode`, fields, `pc` and the flags change only on clock edges. `opcode` is stable for the whole EXEC cycle.
- Jump latency: target is on `imem_addr` in the FETCH cycle immediately after EXEC.

## Configuration
- `FETCH_SEQ_STEP_EN` defined:
  - Adds input `step` (1 bit) and state STEP_WAIT.
  - After every non-halting EXEC the FSM enters STEP_WAIT regardless of `run`.
  - It leaves to FETCH on the first cycle `step`=1, or to IDLE if `run`=0 in that cycle.
  - `step` held high advances one instruction per visit to STEP_WAIT, not continuously.
- Not defined: no `step` port, no STEP_WAIT; behaviour is exactly as above.

## Test plan
- Reset, `run`=1, zero-wait memory holding 0001_001_010 at address 0 → `imem_rd` high at cycle 1, `exec_valid` at cycle 2 with `opcode`=0001, `pc`=1 after.
- Memory with 3 wait cycles → `imem_addr` stays at 0 for 4 FETCH cycles, single EXEC pulse, `pc` 0→1.
- `jmp_sel`=1 in EXEC with IR=0100_000_101 → next `imem_addr`=5. With `jmp_sel`=0 → 1. With PC_W=3, `pc`=7 and no jump → 0.
- `flag_we`=1 with ALU flags ZF=1 SF=0 CF=1 → `zf`=1, `cf`=1 from the next cycle. `flag_we`=0 in the following EXEC → flags unchanged.
- Opcode 1111 at address 2 → `halted`=1 and `pc`=3 after EXEC, no further `imem_rd` for 20 cycles. `rst_n` pulse → `pc`=0, IDLE.
- `rst_n` low mid-FETCH during a wait → all outputs at reset values asynchronously. With `FETCH_SEQ_STEP_EN`, exactly one EXEC per `step` pulse.
